// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM encodings, default widths and
// the round-robin pointer helper.
package adder_arbiter_pkg;

   localparam int unsigned DefOpW  = 513;
   localparam int unsigned DefCntW = 16;

   typedef logic [1:0] state_t;

   // Encodings are shared with the exponentiation controller; keep them fixed.
   localparam state_t StIdle  = 2'd0;
   localparam state_t StIssue = 2'd1;
   localparam state_t StWait  = 2'd2;
   localparam state_t StResp  = 2'd3;

   function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and adder-side signal bundle for adder_arbiter; the slave modport is
// the arbiter's view, the master modport is the requesters' and adder's view.
interface adder_arbiter_if
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned OP_W    = DefOpW,
   parameter int unsigned CNT_W   = DefCntW
) ();

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_sub;
   logic [NUM_REQ*OP_W-1:0] req_a;
   logic [NUM_REQ*OP_W-1:0] req_b;
   logic [NUM_REQ-1:0]      req_ack;
   logic [NUM_REQ-1:0]      res_done;
   logic [IDX_W-1:0]        res_id;
   logic [OP_W:0]           res_data;
   logic [CNT_W-1:0]        op_cycles;
   logic                    busy;
   logic                    add_start;
   logic                    add_sub;
   logic [OP_W-1:0]         add_a;
   logic [OP_W-1:0]         add_b;
   logic [OP_W:0]           add_result;
   logic                    add_done;

   modport slave (
      input  req_valid, req_sub, req_a, req_b, add_result, add_done,
      output req_ack, res_done, res_id, res_data, op_cycles, busy,
             add_start, add_sub, add_a, add_b
   );

   modport master (
      output req_valid, req_sub, req_a, req_b, add_result, add_done,
      input  req_ack, res_done, res_id, res_data, op_cycles, busy,
             add_start, add_sub, add_a, add_b
   );

endinterface

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping, returned as a one-hot grant plus its index.
module adder_arbiter_rr
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   int unsigned pos;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         pos = (32'(ptr_i) + off) % NUM_REQ;
         if (!any_o && req_i[pos]) begin
            any_o      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-precision add/sub unit among NUM_REQ requesters: round-robin
// grant, operand capture, start/done sequencing, tagged result and latency count.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned OP_W    = DefOpW,
   parameter int unsigned CNT_W   = DefCntW
) (
   input logic          clk,
   input logic          rst,
   adder_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0]   res_id_q, res_id_d;
   logic [OP_W-1:0]    add_a_q, add_a_d;
   logic [OP_W-1:0]    add_b_q, add_b_d;
   logic               add_sub_q, add_sub_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   op_cycles_q, op_cycles_d;
   logic [OP_W:0]      res_data_q, res_data_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic [OP_W-1:0]    sel_a, sel_b;
   logic               sel_sub;

   adder_arbiter_rr #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // AND-OR mux of the granted requester's operand slices.
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_a   = sel_a | bus.req_a[i*OP_W +: OP_W];
            sel_b   = sel_b | bus.req_b[i*OP_W +: OP_W];
            sel_sub = sel_sub | bus.req_sub[i];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      res_id_d    = res_id_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_sub_d   = add_sub_q;
      cnt_d       = cnt_q;
      op_cycles_d = op_cycles_q;
      res_data_d  = res_data_q;
      unique case (state_q)
         StIdle: begin
            if (arb_any) begin
               add_a_d   = sel_a;
               add_b_d   = sel_b;
               add_sub_d = sel_sub;
               gnt_idx_d = arb_idx;
               state_d   = StIssue;
            end
         end
         StIssue: begin
            cnt_d    = CNT_W'(1);
            rr_ptr_d = IDX_W'(wrap_inc(32'(gnt_idx_q), NUM_REQ));
            state_d  = StWait;
         end
         StWait: begin
            if (bus.add_done) begin
               res_data_d  = bus.add_result;
               res_id_d    = gnt_idx_q;
               op_cycles_d = cnt_q;
               state_d     = StResp;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         gnt_idx_q   <= '0;
         res_id_q    <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_sub_q   <= 1'b0;
         cnt_q       <= '0;
         op_cycles_q <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         res_id_q    <= res_id_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_sub_q   <= add_sub_d;
         cnt_q       <= cnt_d;
         op_cycles_q <= op_cycles_d;
         res_data_q  <= res_data_d;
      end
   end

   always_comb begin
      bus.req_ack  = '0;
      bus.res_done = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         bus.req_ack[i]  = (state_q == StIssue) && (gnt_idx_q == IDX_W'(i));
         bus.res_done[i] = (state_q == StResp) && (gnt_idx_q == IDX_W'(i));
      end
   end

   assign bus.res_id    = res_id_q;
   assign bus.res_data  = res_data_q;
   assign bus.op_cycles = op_cycles_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.add_start = (state_q == StIssue);
   assign bus.add_sub   = add_sub_q;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter with a behavioural variable-latency adder.
module tb_adder_arbiter;
   import adder_arbiter_pkg::*;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned OP_W    = 513;
   localparam int unsigned CNT_W   = 16;

   typedef logic [OP_W:0]   res_t;
   typedef logic [OP_W-1:0] op_t;

   typedef struct {
      int   who;
      logic sub;
      op_t  a;
      op_t  b;
      int   lat;
      res_t exp;
   } vec_t;

   typedef struct {
      int   id;
      res_t data;
      int   cyc;
   } exp_t;

   logic clk = 1'b1;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_arbiter_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .CNT_W(CNT_W)) bus ();

   adder_arbiter #(.NUM_REQ(NUM_REQ), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   exp_t sb[$];
   int   gq[$];

   function automatic void chk(string name, res_t got, res_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endfunction

   function automatic res_t model(logic s, op_t a, op_t b);
      return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
   endfunction

   // Adder: done drops on start, rises lat cycles later and stays until next start.
   int   lat = 1;
   int   add_cnt;
   op_t  ma, mb;
   logic msub;
   res_t add_res;
   logic add_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_cnt  <= 0;
         add_done <= 1'b0;
         add_res  <= '0;
         ma       <= '0;
         mb       <= '0;
         msub     <= 1'b0;
      end else if (bus.add_start) begin
         add_cnt  <= lat;
         add_done <= 1'b0;
         ma       <= bus.add_a;
         mb       <= bus.add_b;
         msub     <= bus.add_sub;
      end else if (add_cnt != 0) begin
         add_cnt <= add_cnt - 1;
         if (add_cnt == 1) begin
            add_done <= 1'b1;
            add_res  <= model(msub, ma, mb);
         end
      end
   end

   assign bus.add_result = add_res;
   assign bus.add_done   = add_done;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req_ack != '0) begin
            if (gq.size() == 0) chk("unexpected_ack", res_t'(bus.req_ack), '0);
            else begin
               int g;
               g = gq.pop_front();
               chk("grant", res_t'(bus.req_ack), res_t'(1) << g);
            end
         end
         if (bus.res_done != '0) begin
            if (sb.size() == 0) chk("unexpected_done", res_t'(bus.res_done), '0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("res_done", res_t'(bus.res_done), res_t'(1) << e.id);
               chk("res_id", res_t'(bus.res_id), res_t'(e.id));
               chk("res_data", bus.res_data, e.data);
               chk("op_cycles", res_t'(bus.op_cycles), res_t'(e.cyc));
            end
         end
      end
   end

   function automatic bit all_zero();
      return (bus.req_ack == '0) && (bus.res_done == '0) && (bus.res_id == '0) &&
             (bus.res_data == '0) && (bus.op_cycles == '0) && !bus.busy &&
             !bus.add_start && !bus.add_sub && (bus.add_a == '0) && (bus.add_b == '0);
   endfunction

   task automatic drive(input int who, input logic s, input op_t a, input op_t b);
      bus.req_sub[who]               = s;
      bus.req_a[who*OP_W +: OP_W]    = a;
      bus.req_b[who*OP_W +: OP_W]    = b;
      bus.req_valid[who]             = 1'b1;
   endtask

   task automatic expect_op(input int who, input logic s, input op_t a, input op_t b,
                            input int l);
      exp_t e;
      e.id   = who;
      e.data = model(s, a, b);
      e.cyc  = l + 1;
      gq.push_back(who);
      sb.push_back(e);
   endtask

   // Operands are scrambled on release to prove the arbiter captured them already.
   task automatic wait_ack(input int who, input bit rel, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.req_ack[who] && cyc < 60);
      if (!bus.req_ack[who]) chk("ack_timeout", '0, res_t'(1));
      else begin
         chk("add_start_with_ack", res_t'(bus.add_start), res_t'(1));
         if (rel) begin
            bus.req_valid[who]          = 1'b0;
            bus.req_sub[who]            = ~bus.req_sub[who];
            bus.req_a[who*OP_W +: OP_W] = '1;
            bus.req_b[who*OP_W +: OP_W] = '1;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((bus.busy || sb.size() != 0) && n < 200);
      if (bus.busy || sb.size() != 0)
         chk("idle_timeout", res_t'({bus.busy, sb.size() != 0}), '0);
   endtask

   vec_t vt[4];
   int   cyc;

   initial begin
      bus.req_valid = '0;
      bus.req_sub   = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      vt[0] = '{who: 0, sub: 1'b0, a: op_t'(1), b: op_t'(1), lat: 1, exp: res_t'(2)};
      vt[1] = '{who: 1, sub: 1'b1, a: op_t'(1), b: op_t'(1), lat: 3, exp: res_t'(0)};
      vt[2] = '{who: 0, sub: 1'b1, a: op_t'(3), b: op_t'(5), lat: 2, exp: '1};
      vt[2].exp[0] = 1'b0;
      vt[3] = '{who: 1, sub: 1'b0, a: '1, b: op_t'(1), lat: 4, exp: '0};
      vt[3].exp[OP_W] = 1'b1;

      #20;
      chk("reset_outputs", res_t'(all_zero()), res_t'(1));
      #5 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_outputs", res_t'(all_zero()), res_t'(1));
      end

      // Single operations, alternating requesters.
      for (int i = 0; i < 4; i++) begin
         lat = vt[i].lat;
         drive(vt[i].who, vt[i].sub, vt[i].a, vt[i].b);
         gq.push_back(vt[i].who);
         sb.push_back('{id: vt[i].who, data: vt[i].exp, cyc: vt[i].lat + 1});
         wait_ack(vt[i].who, 1'b1, cyc);
         chk("ack_latency", res_t'(cyc), res_t'(1));
         wait_idle();
      end

      // Two tie rounds: req0 wins each time because the pointer moves past req1.
      lat = 2;
      for (int r = 0; r < 2; r++) begin
         drive(0, 1'b0, op_t'(1), op_t'(1));
         drive(1, 1'b1, op_t'(5), op_t'(3));
         expect_op(0, 1'b0, op_t'(1), op_t'(1), 2);
         expect_op(1, 1'b1, op_t'(5), op_t'(3), 2);
         wait_ack(0, 1'b1, cyc);
         wait_ack(1, 1'b1, cyc);
         wait_idle();
      end

      // Both held for six operations: grants alternate 0,1,0,1,0,1.
      lat = 1;
      drive(0, 1'b0, op_t'(7), op_t'(9));
      drive(1, 1'b1, op_t'(9), op_t'(7));
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) expect_op(0, 1'b0, op_t'(7), op_t'(9), 1);
         else            expect_op(1, 1'b1, op_t'(9), op_t'(7), 1);
      end
      for (int k = 0; k < 6; k++) wait_ack(k % 2, k >= 4, cyc);
      wait_idle();

      // Reset during WAIT of a req0 operation; no result may appear.
      lat = 20;
      drive(0, 1'b0, op_t'(1), op_t'(1));
      gq.push_back(0);
      wait_ack(0, 1'b1, cyc);
      repeat (3) @(negedge clk);
      chk("busy_in_wait", res_t'(bus.busy), res_t'(1));
      #2 rst = 1'b1;
      #1 chk("async_reset", res_t'(all_zero()), res_t'(1));
      @(negedge clk);
      chk("reset_held", res_t'(all_zero()), res_t'(1));
      rst = 1'b0;

      // Pointer must restart at 0 after reset.
      lat = 3;
      drive(0, 1'b0, op_t'(1), op_t'(1));
      drive(1, 1'b1, op_t'(1), op_t'(1));
      expect_op(0, 1'b0, op_t'(1), op_t'(1), 3);
      expect_op(1, 1'b1, op_t'(1), op_t'(1), 3);
      wait_ack(0, 1'b1, cyc);
      wait_ack(1, 1'b1, cyc);
      wait_idle();
      chk("grants_drained", res_t'(gq.size()), '0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
